// File: rtl/health_tracker_if.sv
//------------------------------------------------------------------------------
// health_tracker_if
// Hit/restart inputs and health/result outputs of the scoreboard health tracker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface health_tracker_if;
    logic       hit_a;
    logic       hit_b;
    logic       restart;
    logic [1:0] healthA;
    logic [1:0] healthB;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output hit_a, hit_b, restart,
        input  healthA, healthB, game_over, winner
    );

    modport slave (
        input  hit_a, hit_b, restart,
        output healthA, healthB, game_over, winner
    );
endinterface

`default_nettype wire

// File: rtl/health_tracker.sv
//------------------------------------------------------------------------------
// health_tracker
// Two-player health with per-hit cooldown, PLAYING/GAME_OVER FSM and winner.
// Optional health regeneration enabled by defining HEALTH_REGEN_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module health_tracker #(
    parameter int MAX_HEALTH      = 3,
    parameter int COOLDOWN_CYCLES = 50000000,
    parameter int CD_W            = 26,
    parameter int REGEN_CYCLES    = 500000000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    health_tracker_if.slave   bus
);

    localparam logic [1:0]      c_health_init = 2'(MAX_HEALTH);
    localparam logic [CD_W-1:0] c_cd_load     = CD_W'(COOLDOWN_CYCLES - 1);

    generate
        if ((MAX_HEALTH < 1) || (MAX_HEALTH > 3) || (COOLDOWN_CYCLES < 1) ||
            (REGEN_CYCLES < 1) || ((64'd1 << CD_W) <= 64'(COOLDOWN_CYCLES))) begin : g_param_check
            $error("health_tracker: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_PLAYING   = 1'b0,
        S_GAME_OVER = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_health_a;
    logic [1:0]      r_health_b;
    logic            r_game_over;
    logic [1:0]      r_winner;
    logic [CD_W-1:0] r_cd_a;
    logic [CD_W-1:0] r_cd_b;

    logic            w_acc_a;
    logic            w_acc_b;
    logic [1:0]      w_ha_nxt;
    logic [1:0]      w_hb_nxt;

`ifdef HEALTH_REGEN_EN
    localparam int              c_rg_w    = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;
    localparam logic [c_rg_w-1:0] c_rg_last = c_rg_w'(REGEN_CYCLES - 1);

    logic [c_rg_w-1:0] r_rg_a;
    logic [c_rg_w-1:0] r_rg_b;
    logic              w_rg_wrap_a;
    logic              w_rg_wrap_b;

    assign w_rg_wrap_a = (r_rg_a == c_rg_last);
    assign w_rg_wrap_b = (r_rg_b == c_rg_last);
`endif

    assign w_acc_a = bus.hit_a && (r_cd_a == '0);
    assign w_acc_b = bus.hit_b && (r_cd_b == '0);

    // A hit on the same edge takes precedence over a regen increment.
    always_comb begin
        w_ha_nxt = r_health_a;
        w_hb_nxt = r_health_b;
        if (w_acc_a) begin
            if (r_health_a != 2'd0) w_ha_nxt = r_health_a - 2'd1;
        end
`ifdef HEALTH_REGEN_EN
        else if (w_rg_wrap_a && (r_health_a < c_health_init)) begin
            w_ha_nxt = r_health_a + 2'd1;
        end
`endif
        if (w_acc_b) begin
            if (r_health_b != 2'd0) w_hb_nxt = r_health_b - 2'd1;
        end
`ifdef HEALTH_REGEN_EN
        else if (w_rg_wrap_b && (r_health_b < c_health_init)) begin
            w_hb_nxt = r_health_b + 2'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_PLAYING;
            r_health_a  <= c_health_init;
            r_health_b  <= c_health_init;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_cd_a      <= '0;
            r_cd_b      <= '0;
`ifdef HEALTH_REGEN_EN
            r_rg_a      <= '0;
            r_rg_b      <= '0;
`endif
        end else if (bus.restart) begin
            r_state     <= S_PLAYING;
            r_health_a  <= c_health_init;
            r_health_b  <= c_health_init;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_cd_a      <= '0;
            r_cd_b      <= '0;
`ifdef HEALTH_REGEN_EN
            r_rg_a      <= '0;
            r_rg_b      <= '0;
`endif
        end else if (r_state == S_PLAYING) begin
            r_health_a <= w_ha_nxt;
            r_health_b <= w_hb_nxt;
            if (w_acc_a)              r_cd_a <= c_cd_load;
            else if (r_cd_a != '0)    r_cd_a <= r_cd_a - 1'b1;
            if (w_acc_b)              r_cd_b <= c_cd_load;
            else if (r_cd_b != '0)    r_cd_b <= r_cd_b - 1'b1;
`ifdef HEALTH_REGEN_EN
            if (w_acc_a || w_rg_wrap_a) r_rg_a <= '0;
            else                        r_rg_a <= r_rg_a + 1'b1;
            if (w_acc_b || w_rg_wrap_b) r_rg_b <= '0;
            else                        r_rg_b <= r_rg_b + 1'b1;
`endif
            // winner[1] flags A knocked out, winner[0] flags B knocked out.
            if ((w_ha_nxt == 2'd0) || (w_hb_nxt == 2'd0)) begin
                r_state     <= S_GAME_OVER;
                r_game_over <= 1'b1;
                r_winner    <= {(w_ha_nxt == 2'd0), (w_hb_nxt == 2'd0)};
            end
        end
    end

    assign bus.healthA   = r_health_a;
    assign bus.healthB   = r_health_b;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_health_tracker.sv
//------------------------------------------------------------------------------
// tb_health_tracker
// Directed self-checking bench for health_tracker (COOLDOWN_CYCLES=4).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_health_tracker;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    health_tracker_if bus ();

    health_tracker #(
        .MAX_HEALTH      (3),
        .COOLDOWN_CYCLES (4),
        .CD_W            (3),
        .REGEN_CYCLES    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] ha, input logic [1:0] hb,
                             input logic go, input logic [1:0] win);
        check({tag, ".healthA"},   {2'b00, bus.healthA},   {2'b00, ha});
        check({tag, ".healthB"},   {2'b00, bus.healthB},   {2'b00, hb});
        check({tag, ".game_over"}, {3'b000, bus.game_over}, {3'b000, go});
        check({tag, ".winner"},    {2'b00, bus.winner},    {2'b00, win});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.hit_a = 1'b0;
        bus.hit_b = 1'b0;
        bus.restart = 1'b0;

        step();
        check_all("reset", 2'd3, 2'd3, 1'b0, 2'b00);
        rst_n = 1'b1;
        step();
        check_all("release", 2'd3, 2'd3, 1'b0, 2'b00);

        // Held hit_a: decrements on sampled edges 0, 4 and 8.
        bus.hit_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("hold.k%0d.healthA", k), {2'b00, bus.healthA},
                  (k < 4) ? 4'd2 : ((k < 8) ? 4'd1 : 4'd0));
            check($sformatf("hold.k%0d.game_over", k), {3'b000, bus.game_over},
                  (k >= 8) ? 4'd1 : 4'd0);
        end
        bus.hit_a = 1'b0;
        check_all("a_lost", 2'd0, 2'd3, 1'b1, 2'b10);

        bus.hit_b = 1'b1;
        step();
        bus.hit_b = 1'b0;
        check_all("freeze", 2'd0, 2'd3, 1'b1, 2'b10);

        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check_all("restart", 2'd3, 2'd3, 1'b0, 2'b00);

        bus.hit_b = 1'b1;
        step();
        bus.hit_b = 1'b0;
        check_all("hit_after_restart", 2'd3, 2'd2, 1'b0, 2'b00);

        // Restart overrides a simultaneous hit and leaves A's cooldown clear.
        bus.restart = 1'b1;
        bus.hit_a = 1'b1;
        step();
        check_all("restart_prio", 2'd3, 2'd3, 1'b0, 2'b00);
        bus.restart = 1'b0;
        step();
        bus.hit_a = 1'b0;
        check_all("cd_cleared", 2'd2, 2'd3, 1'b0, 2'b00);

        // Draw: both players step down together to 0.
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        bus.hit_a = 1'b1;
        bus.hit_b = 1'b1;
        step();
        bus.hit_a = 1'b0;
        bus.hit_b = 1'b0;
        check_all("draw1", 2'd2, 2'd2, 1'b0, 2'b00);
        repeat (3) step();
        bus.hit_a = 1'b1;
        bus.hit_b = 1'b1;
        step();
        bus.hit_a = 1'b0;
        bus.hit_b = 1'b0;
        check_all("draw2", 2'd1, 2'd1, 1'b0, 2'b00);
        repeat (3) step();
        bus.hit_a = 1'b1;
        bus.hit_b = 1'b1;
        step();
        bus.hit_a = 1'b0;
        bus.hit_b = 1'b0;
        check_all("draw3", 2'd0, 2'd0, 1'b1, 2'b11);

        // Asynchronous reset mid-round, observed with no clock edge.
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        bus.hit_a = 1'b1;
        step();
        bus.hit_a = 1'b0;
        repeat (3) step();
        bus.hit_a = 1'b1;
        step();
        bus.hit_a = 1'b0;
        check_all("pre_async", 2'd1, 2'd3, 1'b0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 2'd3, 2'd3, 1'b0, 2'b00);
        step();
        rst_n = 1'b1;
        step();

`ifdef HEALTH_REGEN_EN
        bus.hit_a = 1'b1;
        step();
        bus.hit_a = 1'b0;
        check("regen.hit", {2'b00, bus.healthA}, 4'd2);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("regen.wait%0d", k), {2'b00, bus.healthA}, 4'd2);
        end
        step();
        check("regen.up", {2'b00, bus.healthA}, 4'd3);
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("regen.cap%0d", k), {2'b00, bus.healthA}, 4'd3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
